// File: rtl/conv_reg_folded.sv
// conv_reg_folded: time-multiplexed 2-D convolution engine.
//
// A whole image and filter set are captured on an in_valid/in_ready handshake. The engine then
// walks every output pixel with PAR_K parallel MAC lanes, each lane accumulating one filter tap
// per clock. When a lane finishes its last tap it scales/narrows the sum into its result slot.
// After all outputs are written the block holds the results and the job tag until out_ready.
//
// Ports:
//   clk             - clock, everything on the rising edge
//   reset           - synchronous active-high reset
//   fil             - filters, element (k,d,h,w) at ((k*IMG_D+d)*FILTER_H+h)*FILTER_W+w
//   img_data_in     - image, element (d,h,w) at (d*IMG_H+h)*IMG_W+w
//   in_valid        - job offered
//   in_ready        - block is idle and can take a job
//   opaque_in       - tag captured with the job
//   result_data_out - results, element (k,h,w) at (k*RESULT_H+h)*RESULT_W+w
//   out_valid       - results and tag valid
//   out_ready       - consumer takes the results
//   opaque_out      - tag of the job on result_data_out
module conv_reg_folded #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 8,
  parameter int unsigned IMG_H      = 8,
  parameter int unsigned IMG_D      = 2,
  parameter int unsigned FILTER_W   = 3,
  parameter int unsigned FILTER_H   = 3,
  parameter int unsigned RESULT_D   = 4,
  parameter int unsigned STRIDE_W   = 1,
  parameter int unsigned STRIDE_H   = 1,
  parameter int unsigned PAD        = 0,
  parameter int unsigned PAR_K      = 2,
  parameter int unsigned OUT_SHIFT  = 0,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [RESULT_D*IMG_D*FILTER_H*FILTER_W*DATA_WIDTH-1:0] fil,
  input  logic [IMG_D*IMG_H*IMG_W*DATA_WIDTH-1:0]                img_data_in,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [7:0]                                            opaque_in,
  output logic [RESULT_D*((IMG_H+2*PAD-FILTER_H)/STRIDE_H+1)
                *((IMG_W+2*PAD-FILTER_W)/STRIDE_W+1)*DATA_WIDTH-1:0] result_data_out,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [7:0]                                            opaque_out
);

  localparam int unsigned RESULT_W  = (IMG_W + 2 * PAD - FILTER_W) / STRIDE_W + 1;
  localparam int unsigned RESULT_H  = (IMG_H + 2 * PAD - FILTER_H) / STRIDE_H + 1;
  localparam int unsigned TAPS      = IMG_D * FILTER_H * FILTER_W;
  localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + $clog2(TAPS);
  localparam int unsigned NumGrp    = RESULT_D / PAR_K;

  localparam int unsigned FilBits = RESULT_D * IMG_D * FILTER_H * FILTER_W * DATA_WIDTH;
  localparam int unsigned ImgBits = IMG_D * IMG_H * IMG_W * DATA_WIDTH;
  localparam int unsigned ResBits = RESULT_D * RESULT_H * RESULT_W * DATA_WIDTH;
  localparam int unsigned FilAw   = (FilBits > 1) ? $clog2(FilBits) : 1;
  localparam int unsigned ImgAw   = (ImgBits > 1) ? $clog2(ImgBits) : 1;
  localparam int unsigned ResAw   = (ResBits > 1) ? $clog2(ResBits) : 1;

  // Counter widths, each covering 0..N-1.
  localparam int unsigned OhW = (RESULT_H > 1) ? $clog2(RESULT_H) : 1;
  localparam int unsigned OwW = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
  localparam int unsigned GW  = (NumGrp > 1)   ? $clog2(NumGrp)   : 1;
  localparam int unsigned DW  = (IMG_D > 1)    ? $clog2(IMG_D)    : 1;
  localparam int unsigned FhW = (FILTER_H > 1) ? $clog2(FILTER_H) : 1;
  localparam int unsigned FwW = (FILTER_W > 1) ? $clog2(FILTER_W) : 1;

  // Signed copies so coordinate arithmetic can go negative inside the padding border.
  localparam int PadI     = PAD;
  localparam int StrideWI = STRIDE_W;
  localparam int StrideHI = STRIDE_H;
  localparam int ImgWI    = IMG_W;
  localparam int ImgHI    = IMG_H;
  localparam int ImgDI    = IMG_D;
  localparam int FwI      = FILTER_W;
  localparam int FhI      = FILTER_H;
  localparam int ResWI    = RESULT_W;
  localparam int ResHI    = RESULT_H;
  localparam int ParKI    = PAR_K;
  localparam int DataWI   = DATA_WIDTH;

  localparam logic [ACC_WIDTH-1:0] MaxOut = ACC_WIDTH'({DATA_WIDTH{1'b1}});

  if (RESULT_D % PAR_K != 0) begin : gen_bad_par_k
    $error("conv_reg_folded: RESULT_D must be divisible by PAR_K");
  end

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e state_q, state_d;

  logic [ImgBits-1:0] img_q;
  logic [FilBits-1:0] fil_q;
  logic [7:0]         tag_q;

  logic [OhW-1:0] oh_q, oh_d;
  logic [OwW-1:0] ow_q, ow_d;
  logic [GW-1:0]  g_q, g_d;
  logic [DW-1:0]  d_q, d_d;
  logic [FhW-1:0] fh_q, fh_d;
  logic [FwW-1:0] fw_q, fw_d;

  logic [ACC_WIDTH-1:0] acc_q [PAR_K];
  logic [ACC_WIDTH-1:0] acc_d [PAR_K];

  logic [ResBits-1:0] res_q;
  logic [7:0]         opaque_out_q;

  logic last_fw, last_fh, last_d, last_tap, last_g, last_ow, last_oh, last_job;

  // Datapath signals.
  int                      ih, iw, pix_idx;
  logic                    in_img;
  logic [ImgAw-1:0]        pix_lsb;
  logic [DATA_WIDTH-1:0]   pixel;
  logic [FilAw-1:0]        wgt_lsb [PAR_K];
  logic [DATA_WIDTH-1:0]   wgt     [PAR_K];
  logic [2*DATA_WIDTH-1:0] prod    [PAR_K];
  logic [ACC_WIDTH-1:0]    sum     [PAR_K];
  logic [ResAw-1:0]        res_lsb [PAR_K];
  logic [DATA_WIDTH-1:0]   res_val [PAR_K];

  // Scale the accumulator and squeeze it into DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] narrow(input logic [ACC_WIDTH-1:0] x);
    logic [ACC_WIDTH-1:0] y;
    y = x >> OUT_SHIFT;
    if ((SATURATE != 0) && (y > MaxOut)) begin
      return '1;
    end
    return y[DATA_WIDTH-1:0];
  endfunction

  assign last_fw  = (fw_q == FwW'(FILTER_W - 1));
  assign last_fh  = (fh_q == FhW'(FILTER_H - 1));
  assign last_d   = (d_q == DW'(IMG_D - 1));
  assign last_tap = last_fw && last_fh && last_d;
  assign last_g   = (g_q == GW'(NumGrp - 1));
  assign last_ow  = (ow_q == OwW'(RESULT_W - 1));
  assign last_oh  = (oh_q == OhW'(RESULT_H - 1));
  assign last_job = last_tap && last_g && last_ow && last_oh;

  always_comb begin : datapath
    ih      = int'(oh_q) * StrideHI + int'(fh_q) - PadI;
    iw      = int'(ow_q) * StrideWI + int'(fw_q) - PadI;
    in_img  = (ih >= 0) && (ih < ImgHI) && (iw >= 0) && (iw < ImgWI);
    // Out-of-image taps read index 0 and are then forced to zero.
    pix_idx = in_img ? ((int'(d_q) * ImgHI + ih) * ImgWI + iw) : 0;
    pix_lsb = ImgAw'(pix_idx * DataWI);
    pixel   = in_img ? img_q[pix_lsb +: DATA_WIDTH] : '0;
    for (int l = 0; l < PAR_K; l++) begin
      wgt_lsb[l] = FilAw'(((((int'(g_q) * ParKI + l) * ImgDI + int'(d_q)) * FhI
                           + int'(fh_q)) * FwI + int'(fw_q)) * DataWI);
      wgt[l]     = fil_q[wgt_lsb[l] +: DATA_WIDTH];
      prod[l]    = {{DATA_WIDTH{1'b0}}, pixel} * {{DATA_WIDTH{1'b0}}, wgt[l]};
      sum[l]     = acc_q[l] + ACC_WIDTH'(prod[l]);
      res_val[l] = narrow(sum[l]);
      res_lsb[l] = ResAw'((((int'(g_q) * ParKI + l) * ResHI + int'(oh_q)) * ResWI
                           + int'(ow_q)) * DataWI);
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    oh_d    = oh_q;
    ow_d    = ow_q;
    g_d     = g_q;
    d_d     = d_q;
    fh_d    = fh_q;
    fw_d    = fw_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StCompute;
        end
      end
      StCompute: begin
        for (int l = 0; l < PAR_K; l++) begin
          acc_d[l] = last_tap ? '0 : sum[l];
        end
        // Odometer: tap (d,fh,fw) innermost, then group, column, row.
        if (!last_fw) begin
          fw_d = fw_q + FwW'(1);
        end else begin
          fw_d = '0;
          if (!last_fh) begin
            fh_d = fh_q + FhW'(1);
          end else begin
            fh_d = '0;
            if (!last_d) begin
              d_d = d_q + DW'(1);
            end else begin
              d_d = '0;
              if (!last_g) begin
                g_d = g_q + GW'(1);
              end else begin
                g_d = '0;
                if (!last_ow) begin
                  ow_d = ow_q + OwW'(1);
                end else begin
                  ow_d = '0;
                  oh_d = last_oh ? '0 : oh_q + OhW'(1);
                end
              end
            end
          end
        end
        if (last_job) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      oh_q         <= '0;
      ow_q         <= '0;
      g_q          <= '0;
      d_q          <= '0;
      fh_q         <= '0;
      fw_q         <= '0;
      res_q        <= '0;
      opaque_out_q <= '0;
      for (int l = 0; l < PAR_K; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      state_q <= state_d;
      oh_q    <= oh_d;
      ow_q    <= ow_d;
      g_q     <= g_d;
      d_q     <= d_d;
      fh_q    <= fh_d;
      fw_q    <= fw_d;
      acc_q   <= acc_d;
      if ((state_q == StCompute) && last_tap) begin
        for (int l = 0; l < PAR_K; l++) begin
          res_q[res_lsb[l] +: DATA_WIDTH] <= res_val[l];
        end
      end
      if ((state_q == StCompute) && last_job) begin
        opaque_out_q <= tag_q;
      end
    end
  end

  // Job operands are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if ((state_q == StIdle) && in_valid) begin
      img_q <= img_data_in;
      fil_q <= fil;
      tag_q <= opaque_in;
    end
  end

  assign in_ready        = (state_q == StIdle);
  assign out_valid       = (state_q == StDone);
  assign result_data_out = res_q;
  assign opaque_out      = opaque_out_q;

endmodule

// File: tb/tb_conv_reg_folded.sv
module tb_conv_reg_folded;

  localparam int DW = 8, IW = 8, IH = 8, ID = 2, FW = 3, FH = 3, RD = 4;
  localparam int TAPS     = ID * FH * FW;
  localparam int FIL_BITS = RD * ID * FH * FW * DW;
  localparam int IMG_BITS = ID * IH * IW * DW;

  // Instance 0: default parameters.
  localparam int PAD0 = 0, SW0 = 1, SH0 = 1, PK0 = 2, SHIFT0 = 0, SAT0 = 0;
  localparam int RW0 = (IW + 2 * PAD0 - FW) / SW0 + 1;
  localparam int RH0 = (IH + 2 * PAD0 - FH) / SH0 + 1;
  localparam int N0  = RH0 * RW0 * (RD / PK0) * TAPS;
  localparam int RES0_BITS = RD * RH0 * RW0 * DW;

  // Instance 1: padding, asymmetric stride, all lanes, shift and saturation.
  localparam int PAD1 = 1, SW1 = 2, SH1 = 1, PK1 = 4, SHIFT1 = 10, SAT1 = 1;
  localparam int RW1 = (IW + 2 * PAD1 - FW) / SW1 + 1;
  localparam int RH1 = (IH + 2 * PAD1 - FH) / SH1 + 1;
  localparam int N1  = RH1 * RW1 * (RD / PK1) * TAPS;
  localparam int RES1_BITS = RD * RH1 * RW1 * DW;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [FIL_BITS-1:0]  fil;
  logic [IMG_BITS-1:0]  img;
  logic                 in_valid;
  logic [7:0]           opaque_in;
  logic                 out_ready;
  logic                 in_ready0, out_valid0, in_ready1, out_valid1;
  logic [RES0_BITS-1:0] res0;
  logic [RES1_BITS-1:0] res1;
  logic [7:0]           op0, op1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_reg_folded dut0 (
    .clk(clk), .reset(reset), .fil(fil), .img_data_in(img), .in_valid(in_valid),
    .in_ready(in_ready0), .opaque_in(opaque_in), .result_data_out(res0),
    .out_valid(out_valid0), .out_ready(out_ready), .opaque_out(op0)
  );

  conv_reg_folded #(
    .PAD(PAD1), .STRIDE_W(SW1), .STRIDE_H(SH1), .PAR_K(PK1), .OUT_SHIFT(SHIFT1),
    .SATURATE(SAT1)
  ) dut1 (
    .clk(clk), .reset(reset), .fil(fil), .img_data_in(img), .in_valid(in_valid),
    .in_ready(in_ready1), .opaque_in(opaque_in), .result_data_out(res1),
    .out_valid(out_valid1), .out_ready(out_ready), .opaque_out(op1)
  );

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference convolution straight from the definition.
  task automatic model(input logic [FIL_BITS-1:0] f, input logic [IMG_BITS-1:0] im,
                       input int pad, input int sw, input int sh, input int shift,
                       input int sat, output int e [RD][8][8]);
    int rw, rh, ih, iw;
    longint acc, y;
    rw = (IW + 2 * pad - FW) / sw + 1;
    rh = (IH + 2 * pad - FH) / sh + 1;
    for (int k = 0; k < RD; k++)
      for (int h = 0; h < 8; h++)
        for (int w = 0; w < 8; w++) e[k][h][w] = 0;
    for (int k = 0; k < RD; k++)
      for (int oh = 0; oh < rh; oh++)
        for (int ow = 0; ow < rw; ow++) begin
          acc = 0;
          for (int d = 0; d < ID; d++)
            for (int fh = 0; fh < FH; fh++)
              for (int fw = 0; fw < FW; fw++) begin
                ih = oh * sh + fh - pad;
                iw = ow * sw + fw - pad;
                if (ih >= 0 && ih < IH && iw >= 0 && iw < IW)
                  acc += longint'(im[((d * IH + ih) * IW + iw) * DW +: DW])
                       * longint'(f[(((k * ID + d) * FH + fh) * FW + fw) * DW +: DW]);
              end
          y = acc >> shift;
          if (sat != 0) y = (y > 255) ? 255 : y;
          else y = y % 256;
          e[k][oh][ow] = int'(y);
        end
  endtask

  function automatic logic [RES0_BITS-1:0] pack0(input int e [RD][8][8]);
    logic [RES0_BITS-1:0] v;
    v = '0;
    for (int k = 0; k < RD; k++)
      for (int h = 0; h < RH0; h++)
        for (int w = 0; w < RW0; w++) v[((k * RH0 + h) * RW0 + w) * DW +: DW] = 8'(e[k][h][w]);
    return v;
  endfunction

  function automatic logic [RES1_BITS-1:0] pack1(input int e [RD][8][8]);
    logic [RES1_BITS-1:0] v;
    v = '0;
    for (int k = 0; k < RD; k++)
      for (int h = 0; h < RH1; h++)
        for (int w = 0; w < RW1; w++) v[((k * RH1 + h) * RW1 + w) * DW +: DW] = 8'(e[k][h][w]);
    return v;
  endfunction

  function automatic int count_ne0(input logic [RES0_BITS-1:0] v, input logic [7:0] val);
    int n;
    n = 0;
    for (int i = 0; i < RES0_BITS / DW; i++) if (v[i * DW +: DW] !== val) n++;
    return n;
  endfunction

  // Scoreboard: arms on each accept, checks latency, handshake and results every cycle.
  logic [RES0_BITS-1:0] exp0;
  logic [RES1_BITS-1:0] exp1;
  logic [7:0]           expop0, expop1;
  bit                   busy0 = 0, busy1 = 0, armed0 = 0, armed1 = 0;
  int                   lat0, lat1, bad;
  int                   em [RD][8][8];

  always @(negedge clk) begin
    if (reset) begin
      busy0 = 0; busy1 = 0; armed0 = 0; armed1 = 0;
    end else begin
      chk(in_ready0 == !busy0, "in_ready0", in_ready0, !busy0);
      chk(in_ready1 == !busy1, "in_ready1", in_ready1, !busy1);
      if (armed0) begin
        lat0++;
        if (out_valid0) begin
          chk(lat0 == N0, "latency0", lat0, N0);
          armed0 = 0;
        end else if (lat0 > N0) begin
          chk(0, "latency0_timeout", lat0, N0);
          armed0 = 0;
        end
      end
      if (armed1) begin
        lat1++;
        if (out_valid1) begin
          chk(lat1 == N1, "latency1", lat1, N1);
          armed1 = 0;
        end else if (lat1 > N1) begin
          chk(0, "latency1_timeout", lat1, N1);
          armed1 = 0;
        end
      end
      if (out_valid0) begin
        bad = -1;
        for (int i = RES0_BITS / DW - 1; i >= 0; i--) if (res0[i*DW +: DW] !== exp0[i*DW +: DW]) bad = i;
        chk(bad < 0, "result0_first_bad_index", bad, -1);
        chk(op0 == expop0, "opaque0", op0, expop0);
      end
      if (out_valid1) begin
        bad = -1;
        for (int i = RES1_BITS / DW - 1; i >= 0; i--) if (res1[i*DW +: DW] !== exp1[i*DW +: DW]) bad = i;
        chk(bad < 0, "result1_first_bad_index", bad, -1);
        chk(op1 == expop1, "opaque1", op1, expop1);
      end
      if (in_valid && !busy0) begin
        model(fil, img, PAD0, SW0, SH0, SHIFT0, SAT0, em);
        exp0 = pack0(em); expop0 = opaque_in; busy0 = 1; armed0 = 1; lat0 = -1;
      end
      if (in_valid && !busy1) begin
        model(fil, img, PAD1, SW1, SH1, SHIFT1, SAT1, em);
        exp1 = pack1(em); expop1 = opaque_in; busy1 = 1; armed1 = 1; lat1 = -1;
      end
      if (out_valid0 && out_ready) busy0 = 0;
      if (out_valid1 && out_ready) busy1 = 0;
    end
  end

  task automatic set_all(input logic [7:0] v);
    for (int i = 0; i < IMG_BITS / DW; i++) img[i * DW +: DW] = v;
    for (int i = 0; i < FIL_BITS / DW; i++) fil[i * DW +: DW] = v;
  endtask

  task automatic set_rand(input int maxv);
    for (int i = 0; i < IMG_BITS / DW; i++) img[i * DW +: DW] = 8'($urandom_range(0, maxv));
    for (int i = 0; i < FIL_BITS / DW; i++) fil[i * DW +: DW] = 8'($urandom_range(0, maxv));
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (!(in_ready0 && in_ready1) && c < 4000) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 4000) chk(0, name, c, 4000);
  endtask

  // Offer one job, scramble the inputs after the accept, wait until both engines hand off.
  task automatic run_job(input logic [7:0] op, input bit rand_ready);
    int c;
    wait_idle("idle_before_job_timeout");
    opaque_in = op;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    set_rand(255);
    opaque_in = 8'($urandom());
    c = 0;
    while (!(in_ready0 && in_ready1) && c < 4000) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b1;
    if (c >= 4000) chk(0, "job_done_timeout", c, 4000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e [RD][8][8];
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opaque_in = '0; img = '0; fil = '0;

    // Pin the reference model with hand-computed values.
    set_all(8'd1);
    model(fil, img, 0, 1, 1, 0, 0, e);
    chk(e[0][0][0] == 18, "model_ones", e[0][0][0], 18);
    chk(e[3][5][5] == 18, "model_ones_last", e[3][5][5], 18);
    model(fil, img, 1, 1, 1, 0, 0, e);
    chk(e[0][0][0] == 8, "model_pad_corner", e[0][0][0], 8);
    chk(e[2][7][7] == 8, "model_pad_corner2", e[2][7][7], 8);
    chk(e[1][0][3] == 12, "model_pad_edge", e[1][0][3], 12);
    chk(e[3][4][3] == 18, "model_pad_interior", e[3][4][3], 18);
    set_all(8'd255);
    model(fil, img, 0, 1, 1, 0, 0, e);
    chk(e[1][2][3] == 18, "model_255_wrap", e[1][2][3], 18);
    model(fil, img, 0, 1, 1, 0, 1, e);
    chk(e[1][2][3] == 255, "model_255_sat", e[1][2][3], 255);
    model(fil, img, 0, 1, 1, 16, 0, e);
    chk(e[1][2][3] == 17, "model_255_shift16", e[1][2][3], 17);
    fil = '0;
    for (int d = 0; d < ID; d++)
      for (int h = 0; h < IH; h++)
        for (int w = 0; w < IW; w++) img[((d * IH + h) * IW + w) * DW +: DW] = 8'(h * 8 + w);
    for (int k = 0; k < RD; k++) fil[(((k * ID + 0) * FH + 1) * FW + 1) * DW +: DW] = 8'd1;
    model(fil, img, 0, 2, 2, 0, 0, e);
    chk(e[0][2][2] == 45, "model_stride_center", e[0][2][2], 45);
    chk(e[3][0][1] == 11, "model_stride_k3", e[3][0][1], 11);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk(out_valid0 == 0, "reset_out_valid", out_valid0, 0);
    chk(count_ne0(res0, 8'd0) == 0, "reset_result_nonzero", count_ne0(res0, 8'd0), 0);
    chk(op0 == 0, "reset_opaque", op0, 0);
    chk(in_ready0 == 1 && in_ready1 == 1, "reset_in_ready", in_ready0, 1);
    @(posedge clk); #1;

    set_all(8'd1);
    run_job(8'h5A, 1'b0);
    chk(count_ne0(res0, 8'd18) == 0, "ones_not_18", count_ne0(res0, 8'd18), 0);
    chk(op0 == 8'h5A, "ones_opaque", op0, 8'h5A);

    set_all(8'd255);
    run_job(8'hC3, 1'b0);
    chk(count_ne0(res0, 8'd18) == 0, "all255_not_18", count_ne0(res0, 8'd18), 0);

    for (int j = 0; j < 5; j++) begin
      set_rand((j % 2 == 0) ? 255 : 15);
      run_job(8'($urandom()), 1'b1);
    end

    // Backpressure: results held while out_ready is low, in_valid ignored.
    set_rand(255);
    opaque_in = 8'h77; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 2000 && !out_valid0; c++) begin
      @(posedge clk); #1;
    end
    chk(out_valid0 == 1, "bp_valid_rise", out_valid0, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk(out_valid0 == 1, "bp_valid_hold", out_valid0, 1);
      chk(in_ready0 == 0, "bp_in_ready_low", in_ready0, 0);
      chk(op0 == 8'h77, "bp_opaque_hold", op0, 8'h77);
      in_valid = (i == 4);
      opaque_in = (i == 4) ? 8'hEE : 8'h00;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk(out_valid0 == 0, "bp_valid_drop", out_valid0, 0);
    chk(in_ready0 == 1, "bp_in_ready_rise", in_ready0, 1);

    // Reset in the middle of a job.
    wait_idle("idle_before_reset_job_timeout");
    set_all(8'd1);
    opaque_in = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (499) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk(out_valid0 == 0, "midreset_out_valid", out_valid0, 0);
    chk(count_ne0(res0, 8'd0) == 0, "midreset_result_nonzero", count_ne0(res0, 8'd0), 0);
    chk(op0 == 0, "midreset_opaque", op0, 0);
    chk(in_ready0 == 1 && in_ready1 == 1, "midreset_in_ready", in_ready0, 1);
    set_all(8'd1);
    run_job(8'h3C, 1'b0);
    chk(count_ne0(res0, 8'd18) == 0, "after_reset_not_18", count_ne0(res0, 8'd18), 0);
    chk(op0 == 8'h3C, "after_reset_opaque", op0, 8'h3C);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
